// File: rtl/fetch_decode_ctrl.sv
// Instruction-side sequencer for the 24-bit single-cycle datapath: fetches three
// bytes per instruction, decodes the opcode and strobes one execute cycle.
module fetch_decode_ctrl #(
  parameter int          MEM_AW  = 18,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [15:0]       pc_i,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic [23:0]       inst_o,
  output logic              regWrite_o,
  output logic              aluSrc_o,
  output logic              PCSrc_o,
  output logic              immSrc_o,
  output logic [1:0]        aluControl_o,
  output logic              step_o,
  output logic              halted_o,
  output logic              illegal_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_EXEC, S_HALT
  } state_t;

  state_t            state_q;
  logic [7:0]        b0_q, b1_q;
  logic [23:0]       inst_q;
  logic              rw_q, as_q, is_q, ps_q;
  logic [1:0]        alu_q;
  logic              step_q, halted_q, illegal_q;

  logic              req_d;
  logic [1:0]        k_d;
  logic [MEM_AW-1:0] pc_ext, base_addr;
  logic [23:0]       inst_d;
  logic [3:0]        op_d;
  logic [6:0]        dec_d;

  // Returns {legal, regWrite, aluSrc, immSrc, PCSrc, aluControl[1:0]}.
  function automatic logic [6:0] decode(input logic [3:0] op);
    case (op)
      4'b0000: decode = 7'b1_1000_00;
      4'b0001: decode = 7'b1_1000_01;
      4'b0010: decode = 7'b1_1000_10;
      4'b0011: decode = 7'b1_1000_11;
      4'b0100: decode = 7'b1_1100_00;
      4'b0101: decode = 7'b1_1100_01;
      4'b0110: decode = 7'b1_1110_10;
      4'b1000: decode = 7'b1_0111_00;
      default: decode = 7'b0_0000_00;
    endcase
  endfunction

  always_comb begin
    req_d = 1'b0;
    k_d   = 2'd0;
    case (state_q)
      S_F0: begin req_d = 1'b1; k_d = 2'd0; end
      S_F1: begin req_d = 1'b1; k_d = 2'd1; end
      S_F2: begin req_d = 1'b1; k_d = 2'd2; end
      default: begin req_d = 1'b0; k_d = 2'd0; end
    endcase
  end

  // pc*3 computed at full address width so pc=16'hFFFF does not truncate.
  assign pc_ext    = MEM_AW'(pc_i);
  assign base_addr = pc_ext + (pc_ext << 1);

  assign inst_d = {b0_q, b1_q, mem_rdata_i};
  assign op_d   = b0_q[7:4];
  assign dec_d  = decode(op_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      b0_q      <= '0;
      b1_q      <= '0;
      inst_q    <= '0;
      rw_q      <= 1'b0;
      as_q      <= 1'b0;
      is_q      <= 1'b0;
      ps_q      <= 1'b0;
      alu_q     <= 2'b00;
      step_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rw_q   <= 1'b0;
      as_q   <= 1'b0;
      is_q   <= 1'b0;
      ps_q   <= 1'b0;
      alu_q  <= 2'b00;
      step_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) state_q <= S_F0;
        S_F0: if (mem_ack_i) begin
          b0_q    <= mem_rdata_i;
          state_q <= S_F1;
        end
        S_F1: if (mem_ack_i) begin
          b1_q    <= mem_rdata_i;
          state_q <= S_F2;
        end
        S_F2: if (mem_ack_i) begin
          inst_q <= inst_d;
          if (op_d == HALT_OP) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            // Controls are loaded here so they are valid for exactly the EXEC cycle.
            state_q <= S_EXEC;
            step_q  <= 1'b1;
            {rw_q, as_q, is_q, ps_q, alu_q} <= dec_d[5:0];
            if (!dec_d[6]) illegal_q <= 1'b1;
          end
        end
        S_EXEC: state_q <= S_F0;
        S_HALT: if (start_i) begin
          state_q  <= S_F0;
          halted_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_o    = req_d;
  assign mem_addr_o   = req_d ? (base_addr + MEM_AW'(k_d)) : '0;
  assign inst_o       = inst_q;
  assign regWrite_o   = rw_q;
  assign aluSrc_o     = as_q;
  assign immSrc_o     = is_q;
  assign PCSrc_o      = ps_q;
  assign aluControl_o = alu_q;
  assign step_o       = step_q;
  assign halted_o     = halted_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Scoreboard bench for fetch_decode_ctrl: a byte-memory responder with random
// wait states, a PC model that advances on step, and a decode reference table.
module tb_fetch_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pc = 16'd0;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [23:0] inst;
  logic        regWrite, aluSrc, PCSrc, immSrc, step, halted, illegal;
  logic [1:0]  aluControl;

  fetch_decode_ctrl #(.MEM_AW(18), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .start_i(start), .pc_i(pc),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .inst_o(inst), .regWrite_o(regWrite),
    .aluSrc_o(aluSrc), .PCSrc_o(PCSrc), .immSrc_o(immSrc),
    .aluControl_o(aluControl), .step_o(step), .halted_o(halted),
    .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference decode: {regWrite, aluSrc, immSrc, PCSrc, aluControl}
  function automatic logic [5:0] ref_ctrl(input logic [3:0] op);
    case (op)
      4'h0: return {1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      4'h1: return {1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
      4'h2: return {1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      4'h3: return {1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
      4'h4: return {1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
      4'h5: return {1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
      4'h6: return {1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
      4'h8: return {1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
      default: return 6'b0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] op);
    return (op <= 4'h6) || (op == 4'h8);
  endfunction

  typedef struct {
    logic [15:0] pc;
    logic [23:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          ack_addrs[$];
  bit [7:0]    mem[int];

  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'd0;
  bit          stall = 1'b0;
  int          stall_addr = 0;
  bit          zw = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pc_load) pc <= pc_load_val;
    else if (step) pc <= pc + 16'd1;
  end

  // Memory responder
  bit pending = 1'b0;
  int wait_left = 0;
  int req_addr = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!pending) begin
        pending   = 1'b1;
        req_addr  = int'(mem_addr);
        wait_left = zw ? 0 : int'($urandom_range(0, 3));
      end else begin
        chk("addr_stable", mem_addr, req_addr);
      end
      if (stall && int'(mem_addr) == stall_addr) begin
        mem_ack = 1'b0;
      end else if (wait_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
        pending   = 1'b0;
        ack_addrs.push_back(int'(mem_addr));
      end else begin
        wait_left--;
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end else begin
      pending   = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
    end
  end

  // Monitor
  bit          step_prev = 1'b0;
  bit          halted_prev = 1'b0;
  bit          ill_exp = 1'b0;
  logic [23:0] last_inst = 24'h0;
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] op;
    if (rst) begin
      exp_q.delete();
      ack_addrs.delete();
      ill_exp     = 1'b0;
      last_inst   = 24'h0;
      step_prev   = 1'b0;
      halted_prev = 1'b0;
    end else begin
      if (step || (halted && !halted_prev)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=inst %0h expected=none", inst);
        end else begin
          e  = exp_q.pop_front();
          op = e.inst[23:20];
          chk("inst", inst, e.inst);
          chk("halted", halted, (op == 4'hF));
          chk("step", step, (op != 4'hF));
          chk("mem_req_off", mem_req, 0);
          if (op != 4'hF) begin
            chk("ctrl", {regWrite, aluSrc, immSrc, PCSrc, aluControl}, ref_ctrl(op));
            if (!ref_legal(op)) ill_exp = 1'b1;
          end
          chk("fetch_count", ack_addrs.size(), 3);
          if (ack_addrs.size() == 3)
            for (int k = 0; k < 3; k++)
              chk("fetch_addr", ack_addrs[k], int'(e.pc) * 3 + k);
          ack_addrs.delete();
          last_inst = e.inst;
        end
      end else if (mem_req) begin
        chk("inst_hold", inst, last_inst);
      end
      if (!step) chk("ctrl_idle", {regWrite, aluSrc, immSrc, PCSrc, aluControl}, 0);
      else chk("step_width", step_prev, 0);
      chk("illegal", illegal, ill_exp);
      step_prev   = step;
      halted_prev = halted;
    end
  end

  task automatic run_seg(input logic [15:0] p0, input int n, input int fidx,
                         input logic [23:0] finst, input bit zero_wait);
    logic [23:0] w;
    logic [15:0] p;
    logic [3:0]  op;
    int          t0, tstep;
    bit          done;
    zw = zero_wait;
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = p0;
    @(negedge clk);
    pc_load = 1'b0;
    for (int i = 0; i <= n; i++) begin
      p = p0 + 16'(i);
      if (i == n) w = {4'hF, 20'($urandom)};
      else if (i == fidx) w = finst;
      else begin
        op = 4'($urandom_range(0, 14));
        w  = {op, 20'($urandom)};
      end
      mem[int'(p) * 3]     = w[23:16];
      mem[int'(p) * 3 + 1] = w[15:8];
      mem[int'(p) * 3 + 2] = w[7:0];
      exp_q.push_back('{pc: p, inst: w});
    end
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    tstep = -1;
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (step && tstep < 0) tstep = cyc;
      if (halted && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("segment_done", done, 1);
    chk("segment_drained", exp_q.size(), 0);
    if (zero_wait) chk("first_step_latency", tstep - t0, 4);
  endtask

  task automatic reset_mid_fetch();
    bit seen;
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = 16'd100;
    @(negedge clk);
    pc_load = 1'b0;
    mem[300] = 8'h41;
    mem[301] = 8'h22;
    mem[302] = 8'h33;
    zw = 1'b0;
    stall = 1'b1;
    stall_addr = 301;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (mem_req && int'(mem_addr) == 301) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_F1", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_ctrl", {regWrite, aluSrc, immSrc, PCSrc, aluControl, step}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    stall = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_no_req", mem_req, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    #12;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_inst", inst, 0);
    chk("reset_step", step, 0);
    chk("reset_halted", halted, 0);
    chk("reset_illegal", illegal, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_wait_start", mem_req, 0);
    end
    run_seg(16'd5, 1, 0, 24'h401234, 1'b1);
    run_seg(pc, 3, 1, 24'h6ABCDE, 1'b0);
    run_seg(16'hFFFD, 3, 2, 24'h812345, 1'b0);
    chk("pc_wrapped", pc, 16'h0000);
    run_seg(pc, 2, 1, 24'h7ABCDE, 1'b0);
    chk("illegal_sticky_in_halt", illegal, 1);
    for (int s = 0; s < 8; s++)
      run_seg(pc, int'($urandom_range(1, 6)), -1, 24'h0, 1'($urandom_range(0, 1)));
    reset_mid_fetch();
    for (int s = 0; s < 3; s++)
      run_seg(pc, int'($urandom_range(1, 6)), -1, 24'h0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
